md_unit_param: RTL and testbench
================================

Name: md_unit_param

Overview:
- Parametrised multi-cycle multiply/divide unit holding the architectural HI/LO registers.
- Sits in the EX stage beside the ALU.
- Supersedes the fixed-latency 32-bit multdiv unit:
  - configurable data width and per-class latency;
  - multiply-accumulate/subtract modes;
  - explicit done pulse;
  - cancellation of an in-flight operation on an exception/interrupt flush.
- The controller stalls D on (start || busy) and reads hi/lo for mfhi/mflo.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, cycles from start edge to HI/LO commit for mult/madd/msub class (>=1).
- DIV_LAT, 10, cycles from start edge to HI/LO commit for div class (>=1).
- CNT_W, 4, width of the latency down-counter; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (clock clk; asynchronous, active-low reset)
- start  in  1  launch op this cycle (E-stage instruction is an MD op)
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; 11-15 treated as none
- a  in  WIDTH  forwarded rs value
- b  in  WIDTH  forwarded rt value
- flush  in  1  exception/interrupt request; cancels in-flight op and blocks same-cycle start
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse, the cycle HI/LO first shows a new arithmetic result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset low, asynchronous): hi=0, lo=0, busy=0, done=0, state IDLE, counter=0, shadow results=0.
- States:
  - IDLE, BUSY.
  - IDLE->BUSY on edge with start=1, flush=0, op in 1..8.
  - BUSY->IDLE on the commit edge or on a flush edge.
- Launch:
  - Result is computed from a/b/hi/lo sampled at the start edge into shadow registers.
  - counter loaded with LAT-1 (MUL_LAT for ops 1,2,5-8; DIV_LAT for 3,4).
  - busy=1 from the cycle after the start edge.
- Commit:
  - In BUSY with counter==0, the next edge writes shadow values to hi/lo and clears busy.
  - done=1 for exactly that one following cycle.
  - Total: hi/lo show the result LAT+1 cycles after the start cycle (start in cycle t -> visible in cycle t+LAT+1).
  - busy is high cycles t+1..t+LAT.
- Otherwise in BUSY, counter decrements each edge.
- mthi/mtlo (ops 9/10):
  - In IDLE with start=1, flush=0, hi (or lo) <= a on that edge.
  - No busy, no done.
- start while busy: ignored (controller guarantees stall; must not corrupt state).
- start with op none/11-15: no effect.
- flush:
  - In BUSY: next edge returns to IDLE; busy=0, done=0; hi/lo keep pre-launch values; shadow discarded.
  - flush in the same cycle as start: start ignored, including mthi/mtlo.
  - flush coinciding with the commit edge: cancel wins, hi/lo unchanged.
- Arithmetic:
  - mult/multu: {hi,lo} = signed/unsigned a*b, full 2*WIDTH product.
  - madd(u): {hi,lo} + product.
  - msub(u): {hi,lo} - product.
  - All wrap modulo 2^(2*WIDTH).
  - div/divu: lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - Divide by zero: lo = all ones, hi = a.
  - Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
- Reset asserted mid-operation: immediate return to reset values; no commit after release.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3, MUL_LAT=5, start cycle 0 -> busy cycles 1-5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1 only in cycle 6.
- divu a=7, b=2 -> cycle DIV_LAT+1 lo=3, hi=1. div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=5, b=0 -> lo=0xFFFFFFFF, hi=5. div 0x80000000 by -1 -> lo=0x80000000, hi=0.
- mthi a=0x12345678 then mtlo a=1, then maddu a=0xFFFFFFFF, b=2 -> hi=0x12345679, lo=0xFFFFFFFF. Then msubu a=1, b=1 -> hi=0x12345679, lo=0xFFFFFFFE.
- Cancellation:
  - hi/lo preloaded 0xA/0xB; start mult 3*4; assert flush in cycle 3 -> busy=0 in cycle 4, done never pulses, hi=0xA, lo=0xB.
  - flush with start mtlo -> lo stays 0xB.
  - flush exactly on the commit cycle -> hi/lo unchanged.
- start mult while busy with different operands -> ignored; first result commits at original time, busy not extended.
- Drive reset low asynchronously (between edges) during BUSY -> hi=lo=0, busy=0 immediately; after release no done pulse. Repeat one scenario with MUL_LAT=1, DIV_LAT=1, WIDTH=16.

Source files
------------

// File: rtl/md_unit_param.sv
// md_unit_param: multi-cycle multiply/divide unit that owns the HI/LO registers.
// The result is computed at the start edge into shadow registers. A down-counter
// then holds it back until the configured latency expires, at which point it is
// committed to HI/LO. A flush discards an in-flight result without touching HI/LO.
//
// state | meaning
// IDLE  | no operation in flight; mthi/mtlo and launches are accepted
// BUSY  | shadow result waiting for the counter to reach terminal count
module md_unit_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV  = 4'd3,
                         OP_DIVU  = 4'd4, OP_MADD  = 4'd5, OP_MADDU = 4'd6,
                         OP_MSUB  = 4'd7, OP_MSUBU = 4'd8, OP_MTHI = 4'd9,
                         OP_MTLO  = 4'd10;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     shi_q, shi_d, slo_q, slo_d;
  logic                 done_q, done_d;

  logic                 is_signed, is_div, is_arith;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod, acc, mres;
  logic [WIDTH-1:0]     mag_a, mag_b, dvd, dvs, uq, ur, quot, rem;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // Result datapath: one multiplier and one unsigned divider shared by all
  // signed/unsigned variants. Signed division runs on magnitudes, so the
  // most-negative / -1 case falls out as quotient = a, remainder = 0.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_arith  = (op >= OP_MULT) && (op <= OP_MSUBU);
    a_ext     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod      = a_ext * b_ext;
    acc       = {hi_q, lo_q};
    case (op)
      OP_MADD, OP_MADDU: mres = acc + prod;
      OP_MSUB, OP_MSUBU: mres = acc - prod;
      default:           mres = prod;
    endcase
    mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    dvd   = is_signed ? mag_a : a;
    dvs   = is_signed ? mag_b : b;
    uq    = dvd / dvs;
    ur    = dvd % dvs;
    quot  = (is_signed && (a[WIDTH-1] ^ b[WIDTH-1])) ? (~uq + 1'b1) : uq;
    rem   = (is_signed && a[WIDTH-1]) ? (~ur + 1'b1) : ur;
    if (is_div) begin
      if (b == '0) begin
        res_hi = a;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end else begin
      res_hi = mres[2*WIDTH-1:WIDTH];
      res_lo = mres[WIDTH-1:0];
    end
  end

  // Next-state: launch, countdown, commit, cancel and direct HI/LO moves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (op == OP_MTHI) hi_d = a;
          if (op == OP_MTLO) lo_d = a;
          if (is_arith) begin
            state_d = BUSY;
            cnt_d   = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            shi_d   = res_hi;
            slo_d   = res_lo;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
          hi_d    = shi_q;
          lo_d    = slo_q;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset is asynchronous and active low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Directed bench for md_unit_param: a vector table for the arithmetic classes
// plus hand-written sequences for cancellation, stall and reset corners, and a
// second narrow single-cycle-latency instance.
module tb_md_unit_param;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, flush = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        s_start = 1'b0, s_flush = 1'b0;
  logic [3:0]  s_op = 4'd0;
  logic [15:0] s_a = '0, s_b = '0;
  logic        s_busy, s_done;
  logic [15:0] s_hi, s_lo;

  int total = 0;
  int bad = 0;

  md_unit_param #(.WIDTH(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo));

  md_unit_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(1), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .op(s_op), .a(s_a), .b(s_b), .flush(s_flush),
    .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input logic [3:0] o, input logic [31:0] v);
    start = 1'b1; op = o; a = v;
    tick();
    start = 1'b0; op = 4'd0;
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    move(4'd9, h);
    chk("mthi_hi", hi, h);
    chk("mthi_busy", busy, 0);
    move(4'd10, l);
    chk("mtlo_lo", lo, l);
    chk("mtlo_done", done, 0);
  endtask

  // Launch an op and check busy over its latency, then the commit cycle.
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    lat = (v.op == 4'd3 || v.op == 4'd4) ? DIV_LAT : MUL_LAT;
    preload(v.pre_hi, v.pre_lo);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    tick();
    start = 1'b0; op = 4'd0;
    for (int k = 1; k <= lat; k++) begin
      chk($sformatf("v%0d_busy_c%0d", idx, k), {busy, done}, 2'b10);
      tick();
    end
    chk($sformatf("v%0d_commit_busy_done", idx), {busy, done}, 2'b01);
    chk($sformatf("v%0d_hi", idx), hi, v.exp_hi);
    chk($sformatf("v%0d_lo", idx), lo, v.exp_lo);
    tick();
    chk($sformatf("v%0d_done_drop", idx), done, 0);
  endtask

  initial begin
    vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h0,        32'h0,        32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{4'd4, 32'd7,        32'd2,        32'h0,        32'h0,        32'h00000001, 32'h00000003};
    vecs[3]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{4'd3, 32'd5,        32'd0,        32'h0,        32'h0,        32'h00000005, 32'hFFFFFFFF};
    vecs[5]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00000000, 32'h80000000};
    vecs[6]  = '{4'd4, 32'd5,        32'd0,        32'h0,        32'h0,        32'h00000005, 32'hFFFFFFFF};
    vecs[7]  = '{4'd6, 32'hFFFFFFFF, 32'd2,        32'h12345678, 32'h00000001, 32'h12345679, 32'hFFFFFFFF};
    vecs[8]  = '{4'd8, 32'd1,        32'd1,        32'h12345679, 32'hFFFFFFFF, 32'h12345679, 32'hFFFFFFFE};
    vecs[9]  = '{4'd5, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[10] = '{4'd7, 32'd1,        32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[11] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        32'h0,        32'h3FFFFFFF, 32'h00000001};

    // Reset state
    tick();
    tick();
    chk("rst_state", {busy, done, hi, lo}, '0);
    chk("rst_state_s", {s_busy, s_done, s_hi, s_lo}, '0);
    #2 reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) run_op(vecs[i], i);

    // Undefined op codes have no effect
    preload(32'h11, 32'h22);
    move(4'd13, 32'hDEAD);
    chk("op13_busy", busy, 0);
    chk("op13_hilo", {hi, lo}, {32'h11, 32'h22});

    // Flush mid-operation
    preload(32'hA, 32'hB);
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    tick();                                   // cycle 1
    start = 1'b0; op = 4'd0;
    tick();                                   // cycle 2
    tick();                                   // cycle 3
    flush = 1'b1;
    tick();                                   // cycle 4
    flush = 1'b0;
    chk("flush_mid_busy", busy, 0);
    for (int k = 0; k < MUL_LAT + 2; k++) begin
      chk($sformatf("flush_mid_nodone_%0d", k), done, 0);
      tick();
    end
    chk("flush_mid_hilo", {hi, lo}, {32'hA, 32'hB});

    // Flush blocks same-cycle start, including moves
    start = 1'b1; op = 4'd10; a = 32'h55; flush = 1'b1;
    tick();
    chk("flush_mtlo_lo", lo, 32'hB);
    op = 4'd9;
    tick();
    chk("flush_mthi_hi", hi, 32'hA);
    op = 4'd1; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; flush = 1'b0; op = 4'd0;
    chk("flush_mult_nobusy", busy, 0);

    // Flush on the commit edge cancels the result
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    tick();
    start = 1'b0; op = 4'd0;
    for (int k = 1; k < MUL_LAT; k++) tick();
    chk("flush_commit_prebusy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_commit_busy_done", {busy, done}, 2'b00);
    chk("flush_commit_hilo", {hi, lo}, {32'hA, 32'hB});
    tick();
    chk("flush_commit_nodone", done, 0);

    // Start while busy is ignored
    preload(32'h0, 32'h0);
    start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
    tick();                                   // t+1
    start = 1'b0; op = 4'd0;
    tick();                                   // t+2
    start = 1'b1; op = 4'd1; a = 32'd5; b = 32'd6;
    tick();                                   // t+3
    tick();                                   // t+4
    start = 1'b0; op = 4'd0;
    tick();                                   // t+5
    chk("stall_last_busy", {busy, done}, 2'b10);
    tick();                                   // t+6
    chk("stall_commit", {busy, done}, 2'b01);
    chk("stall_hilo", {hi, lo}, {32'h0, 32'hC});
    tick();
    chk("stall_after", {busy, done}, 2'b00);

    // Asynchronous reset while busy
    preload(32'h77, 32'h88);
    start = 1'b1; op = 4'd4; a = 32'd9; b = 32'd2;
    tick();
    start = 1'b0; op = 4'd0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_state", {busy, done, hi, lo}, '0);
    #2 reset = 1'b1;
    for (int k = 0; k < DIV_LAT + 3; k++) begin
      tick();
      chk($sformatf("arst_quiet_%0d", k), {busy, done, hi, lo}, '0);
    end

    // Narrow instance with single-cycle latency
    s_start = 1'b1; s_op = 4'd1; s_a = 16'hFFFE; s_b = 16'd3;
    tick();
    s_start = 1'b0; s_op = 4'd0;
    chk("s_mult_busy", {s_busy, s_done}, 2'b10);
    tick();
    chk("s_mult_commit", {s_busy, s_done}, 2'b01);
    chk("s_mult_hilo", {s_hi, s_lo}, {16'hFFFF, 16'hFFFA});
    tick();
    chk("s_mult_drop", s_done, 0);
    s_start = 1'b1; s_op = 4'd3; s_a = 16'hFFF9; s_b = 16'd2;
    tick();
    s_start = 1'b0; s_op = 4'd0;
    s_flush = 1'b0;
    tick();
    chk("s_div_hilo", {s_hi, s_lo}, {16'hFFFF, 16'hFFFD});
    s_start = 1'b1; s_op = 4'd1; s_a = 16'd3; s_b = 16'd4;
    tick();
    s_start = 1'b0; s_op = 4'd0;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    chk("s_flush_commit", {s_busy, s_done, s_hi, s_lo}, {2'b00, 16'hFFFF, 16'hFFFD});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
